// File: rtl/dma2mem_txn_monitor.sv
// rtl/dma2mem_txn_monitor.sv - per-lane DMA/memory-controller transaction monitor with round-robin record drain
// Ports:
//   clk, reset_poweron                    clock, synchronous active-high reset
//   sys__mon__enable, sys__mon__clear     capture enable, synchronous clear of all monitor state
//   dma__memc__* / memc__dma__*           per-lane write, read request and read data taps (flattened by lane)
//   mon__out_* / out__mon_ready           single-slot valid/ready record stream
//   mon__overflow, mon__drop_count        per-lane sticky drop flag and saturating drop counter
module dma2mem_txn_monitor #(
  parameter int NUM_LANES     = 32,
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int TS_WIDTH      = 16,
  parameter int CAPTURE_READS = 1,
  parameter int DROP_WIDTH    = 8,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                             clk,
  input  logic                             reset_poweron,
  input  logic                             sys__mon__enable,
  input  logic                             sys__mon__clear,
  input  logic [NUM_LANES-1:0]             dma__memc__write_valid,
  input  logic [NUM_LANES-1:0]             memc__dma__write_ready,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]  dma__memc__write_address,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  dma__memc__write_data,
  input  logic [NUM_LANES-1:0]             dma__memc__read_valid,
  input  logic [NUM_LANES-1:0]             memc__dma__read_ready,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]  dma__memc__read_address,
  input  logic [NUM_LANES-1:0]             memc__dma__read_data_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  memc__dma__read_data,
  output logic                             mon__out_valid,
  input  logic                             out__mon_ready,
  output logic [LW-1:0]                    mon__out_lane,
  output logic [1:0]                       mon__out_type,
  output logic [ADDR_WIDTH-1:0]            mon__out_address,
  output logic [DATA_WIDTH-1:0]            mon__out_data,
  output logic [TS_WIDTH-1:0]              mon__out_timestamp,
  output logic [NUM_LANES-1:0]             mon__overflow,
  output logic [NUM_LANES*DROP_WIDTH-1:0]  mon__drop_count
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = DROP_WIDTH + 2;
  localparam int REC_W = 2 + ADDR_WIDTH + DATA_WIDTH + TS_WIDTH;
  localparam bit READS_ON = (CAPTURE_READS != 0);
  localparam logic [1:0] T_WR  = 2'd0;
  localparam logic [1:0] T_RDQ = 2'd1;
  localparam logic [1:0] T_RDD = 2'd2;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  // Record layout: {type, address, data, timestamp}
  logic [REC_W-1:0]      mem_q    [NUM_LANES][FIFO_DEPTH];
  logic [REC_W-1:0]      mem_d    [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]         wptr_q   [NUM_LANES];
  logic [PW-1:0]         wptr_d   [NUM_LANES];
  logic [PW-1:0]         rptr_q   [NUM_LANES];
  logic [PW-1:0]         rptr_d   [NUM_LANES];
  logic [CW-1:0]         cnt_q    [NUM_LANES];
  logic [CW-1:0]         cnt_d    [NUM_LANES];
  logic [DROP_WIDTH-1:0] drop_q   [NUM_LANES];
  logic [DROP_WIDTH-1:0] drop_d   [NUM_LANES];
  logic [NUM_LANES-1:0]  ovf_q, ovf_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [LW-1:0]         rr_ptr_q, rr_ptr_d;

  logic                  out_valid_q, out_valid_d;
  logic [LW-1:0]         out_lane_q, out_lane_d;
  logic [1:0]            out_type_q, out_type_d;
  logic [ADDR_WIDTH-1:0] out_address_q, out_address_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TS_WIDTH-1:0]   out_timestamp_q, out_timestamp_d;

  logic [NUM_LANES-1:0]  ev_wr, ev_rdq, ev_rdd, pop;
  logic                  slot_free, grant_found;
  logic [LW-1:0]         grant_lane, arb_lane;
  logic [REC_W-1:0]      grant_rec;
  int                    arb_idx;

  logic [REC_W-1:0]      push_rec;
  logic                  push_any, push_ok;
  logic [1:0]            n_ev, n_drop;
  logic [SW-1:0]         drop_sum;

  assign ev_wr  = {NUM_LANES{sys__mon__enable}} & dma__memc__write_valid & memc__dma__write_ready;
  assign ev_rdq = {NUM_LANES{sys__mon__enable & READS_ON}} & dma__memc__read_valid & memc__dma__read_ready;
  assign ev_rdd = {NUM_LANES{sys__mon__enable & READS_ON}} & memc__dma__read_data_valid;

  // Round-robin search over non-empty FIFOs, starting at rr_ptr_q
  always_comb begin
    slot_free   = !out_valid_q || out__mon_ready;
    grant_found = 1'b0;
    grant_lane  = '0;
    arb_lane    = '0;
    arb_idx     = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NUM_LANES) arb_idx = arb_idx - NUM_LANES;
      arb_lane = LW'(arb_idx);
      if (!grant_found && cnt_q[arb_lane] != '0) begin
        grant_found = 1'b1;
        grant_lane  = arb_lane;
      end
    end
    grant_rec = mem_q[grant_lane][rptr_q[grant_lane]];
    pop = '0;
    if (slot_free && grant_found) pop[grant_lane] = 1'b1;
  end

  always_comb begin
    mem_d           = mem_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    cnt_d           = cnt_q;
    drop_d          = drop_q;
    ovf_d           = ovf_q;
    ts_d            = ts_q + 1'b1;
    rr_ptr_d        = rr_ptr_q;
    out_valid_d     = out_valid_q;
    out_lane_d      = out_lane_q;
    out_type_d      = out_type_q;
    out_address_d   = out_address_q;
    out_data_d      = out_data_q;
    out_timestamp_d = out_timestamp_q;
    push_rec        = '0;
    push_any        = 1'b0;
    push_ok         = 1'b0;
    n_ev            = '0;
    n_drop          = '0;
    drop_sum        = '0;

    if (slot_free) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        {out_type_d, out_address_d, out_data_d, out_timestamp_d} = grant_rec;
        out_lane_d = grant_lane;
        rr_ptr_d   = (grant_lane == LW'(NUM_LANES - 1)) ? '0 : grant_lane + 1'b1;
      end
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      n_ev     = 2'(ev_wr[i]) + 2'(ev_rdd[i]) + 2'(ev_rdq[i]);
      push_any = ev_wr[i] | ev_rdd[i] | ev_rdq[i];
      if (ev_wr[i])
        push_rec = {T_WR, dma__memc__write_address[i*ADDR_WIDTH +: ADDR_WIDTH],
                    dma__memc__write_data[i*DATA_WIDTH +: DATA_WIDTH], ts_q};
      else if (ev_rdd[i])
        push_rec = {T_RDD, {ADDR_WIDTH{1'b0}}, memc__dma__read_data[i*DATA_WIDTH +: DATA_WIDTH], ts_q};
      else
        push_rec = {T_RDQ, dma__memc__read_address[i*ADDR_WIDTH +: ADDR_WIDTH], {DATA_WIDTH{1'b0}}, ts_q};
      // A full FIFO still takes the record when the arbiter frees a slot at the same edge
      push_ok = push_any && ((cnt_q[i] != CW'(FIFO_DEPTH)) || pop[i]);
      n_drop  = n_ev - 2'(push_ok);
      if (push_ok) begin
        mem_d[i][wptr_q[i]] = push_rec;
        wptr_d[i] = wptr_q[i] + 1'b1;
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + 1'b1;
      cnt_d[i]  = cnt_q[i] + CW'(push_ok) - CW'(pop[i]);
      drop_sum  = SW'(drop_q[i]) + SW'(n_drop);
      drop_d[i] = (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
      if (n_drop != 2'd0) ovf_d[i] = 1'b1;
    end

    // Clear wins over both capture and drain in its cycle
    if (sys__mon__clear) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
        drop_d[i] = '0;
      end
      ovf_d           = '0;
      ts_d            = '0;
      rr_ptr_d        = '0;
      out_valid_d     = 1'b0;
      out_lane_d      = '0;
      out_type_d      = '0;
      out_address_d   = '0;
      out_data_d      = '0;
      out_timestamp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        drop_q[i] <= '0;
      end
      ovf_q           <= '0;
      ts_q            <= '0;
      rr_ptr_q        <= '0;
      out_valid_q     <= 1'b0;
      out_lane_q      <= '0;
      out_type_q      <= '0;
      out_address_q   <= '0;
      out_data_q      <= '0;
      out_timestamp_q <= '0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      cnt_q           <= cnt_d;
      drop_q          <= drop_d;
      ovf_q           <= ovf_d;
      ts_q            <= ts_d;
      rr_ptr_q        <= rr_ptr_d;
      out_valid_q     <= out_valid_d;
      out_lane_q      <= out_lane_d;
      out_type_q      <= out_type_d;
      out_address_q   <= out_address_d;
      out_data_q      <= out_data_d;
      out_timestamp_q <= out_timestamp_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign mon__out_valid     = out_valid_q;
  assign mon__out_lane      = out_lane_q;
  assign mon__out_type      = out_type_q;
  assign mon__out_address   = out_address_q;
  assign mon__out_data      = out_data_q;
  assign mon__out_timestamp = out_timestamp_q;
  assign mon__overflow      = ovf_q;

  always_comb begin
    mon__drop_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mon__drop_count[i*DROP_WIDTH +: DROP_WIDTH] = drop_q[i];
    end
  end

endmodule

// File: tb/tb_dma2mem_txn_monitor.sv
// tb/tb_dma2mem_txn_monitor.sv - directed and randomized self-checking bench for dma2mem_txn_monitor
module tb_dma2mem_txn_monitor;

  localparam int NL  = 32;
  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int FD  = 4;
  localparam int TW  = 16;
  localparam int DRW = 8;
  localparam int LW  = 5;

  logic clk;
  logic reset_poweron, en, clr, ready;
  logic [NL-1:0]    wv, wr, rv, rr, rdv;
  logic [NL*AW-1:0] wa, ra;
  logic [NL*DW-1:0] wd, rd;

  logic            o_valid, b_valid;
  logic [LW-1:0]   o_lane, b_lane;
  logic [1:0]      o_type, b_type;
  logic [AW-1:0]   o_addr, b_addr;
  logic [DW-1:0]   o_data, b_data;
  logic [TW-1:0]   o_ts, b_ts;
  logic [NL-1:0]   o_ovf, b_ovf;
  logic [NL*DRW-1:0] o_drop, b_drop;

  dma2mem_txn_monitor dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .sys__mon__enable(en), .sys__mon__clear(clr),
    .dma__memc__write_valid(wv), .memc__dma__write_ready(wr),
    .dma__memc__write_address(wa), .dma__memc__write_data(wd),
    .dma__memc__read_valid(rv), .memc__dma__read_ready(rr),
    .dma__memc__read_address(ra), .memc__dma__read_data_valid(rdv),
    .memc__dma__read_data(rd),
    .mon__out_valid(o_valid), .out__mon_ready(ready), .mon__out_lane(o_lane),
    .mon__out_type(o_type), .mon__out_address(o_addr), .mon__out_data(o_data),
    .mon__out_timestamp(o_ts), .mon__overflow(o_ovf), .mon__drop_count(o_drop)
  );

  dma2mem_txn_monitor #(.CAPTURE_READS(0)) dut_wo (
    .clk(clk), .reset_poweron(reset_poweron),
    .sys__mon__enable(en), .sys__mon__clear(clr),
    .dma__memc__write_valid(wv), .memc__dma__write_ready(wr),
    .dma__memc__write_address(wa), .dma__memc__write_data(wd),
    .dma__memc__read_valid(rv), .memc__dma__read_ready(rr),
    .dma__memc__read_address(ra), .memc__dma__read_data_valid(rdv),
    .memc__dma__read_data(rd),
    .mon__out_valid(b_valid), .out__mon_ready(ready), .mon__out_lane(b_lane),
    .mon__out_type(b_type), .mon__out_address(b_addr), .mon__out_data(b_data),
    .mon__out_timestamp(b_ts), .mon__overflow(b_ovf), .mon__drop_count(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-lane queues of whole records plus one output slot
  typedef struct packed {
    logic [LW-1:0] lane;
    logic [1:0]    typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] ts;
  } rec_t;

  rec_t          mq [NL][$];
  rec_t          m_rec, r, dut_rec;
  bit            m_valid, have, started;
  int            m_rr, m_ts, g, l, nev, acc, dropped;
  int            m_drop [NL];
  logic [NL-1:0] m_ovf;
  logic [NL*DRW-1:0] m_drop_flat;

  task automatic compare_outputs();
    dut_rec = {o_lane, o_type, o_addr, o_data, o_ts};
    for (int i = 0; i < NL; i++) m_drop_flat[i*DRW +: DRW] = DRW'(m_drop[i]);
    check_eq("out_valid", 256'(o_valid), 256'(m_valid));
    if (m_valid) check_eq("out_record", 256'(dut_rec), 256'(m_rec));
    check_eq("overflow", 256'(o_ovf), 256'(m_ovf));
    check_eq("drop_count", 256'(o_drop), 256'(m_drop_flat));
  endtask

  task automatic model_step();
    if (reset_poweron || clr) begin
      for (int i = 0; i < NL; i++) begin
        mq[i].delete();
        m_drop[i] = 0;
      end
      m_ovf = '0; m_valid = 0; m_rec = '0; m_rr = 0; m_ts = 0;
    end else begin
      if (!m_valid || ready) begin
        g = -1;
        for (int k = 0; k < NL; k++) begin
          l = (m_rr + k) % NL;
          if (g < 0 && mq[l].size() > 0) g = l;
        end
        if (g >= 0) begin
          m_rec = mq[g].pop_front();
          m_valid = 1;
          m_rr = (g + 1) % NL;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < NL; i++) begin
        nev = 0; have = 0; r = '0;
        if (en) begin
          if (wv[i] && wr[i]) begin
            nev++;
            r = {LW'(i), 2'd0, wa[i*AW +: AW], wd[i*DW +: DW], TW'(m_ts)};
            have = 1;
          end
          if (rdv[i]) begin
            nev++;
            if (!have) begin r = {LW'(i), 2'd2, AW'(0), rd[i*DW +: DW], TW'(m_ts)}; have = 1; end
          end
          if (rv[i] && rr[i]) begin
            nev++;
            if (!have) begin r = {LW'(i), 2'd1, ra[i*AW +: AW], DW'(0), TW'(m_ts)}; have = 1; end
          end
        end
        acc = 0;
        if (have && mq[i].size() < FD) begin
          mq[i].push_back(r);
          acc = 1;
        end
        dropped = nev - acc;
        if (dropped > 0) begin
          m_ovf[i] = 1'b1;
          m_drop[i] = (m_drop[i] + dropped > 255) ? 255 : m_drop[i] + dropped;
        end
      end
      m_ts = (m_ts + 1) % (1 << TW);
    end
  endtask

  initial started = 0;
  always @(negedge clk) begin
    if (started) compare_outputs();
    model_step();
    if (reset_poweron) started = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wv = '0; wr = '0; rv = '0; rr = '0; rdv = '0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset_poweron = 1'b1; en = 1'b1; clr = 1'b0; ready = 1'b1;
    idle();
    wa = '0; ra = '0; wd = '0; rd = '0;
    repeat (3) tick();
    check_eq("reset_valid", 256'(o_valid), 256'(0));
    check_eq("reset_drop", 256'(o_drop), 256'(0));
    reset_poweron = 1'b0;

    // Single write on lane 3 at timestamp 10
    do_clear();
    repeat (10) tick();
    wv[3] = 1'b1; wr[3] = 1'b1;
    wa[3*AW +: AW] = 24'h000100; wd[3*DW +: DW] = 32'hDEADBEEF;
    tick(); idle(); tick();
    check_eq("t1_valid", 256'(o_valid), 256'(1));
    check_eq("t1_lane", 256'(o_lane), 256'(3));
    check_eq("t1_data", 256'(o_data), 256'(32'hDEADBEEF));
    check_eq("t1_addr", 256'(o_addr), 256'(24'h000100));
    check_eq("t1_ts", 256'(o_ts), 256'(10));

    // Same-cycle writes on lanes 0, 5, 31 then 0, 31
    do_clear();
    wv[0] = 1'b1; wr[0] = 1'b1; wv[5] = 1'b1; wr[5] = 1'b1; wv[31] = 1'b1; wr[31] = 1'b1;
    tick(); idle(); tick();
    check_eq("t2_first", 256'(o_lane), 256'(0));
    tick();
    check_eq("t2_second", 256'(o_lane), 256'(5));
    tick();
    check_eq("t2_third", 256'(o_lane), 256'(31));
    wv[0] = 1'b1; wr[0] = 1'b1; wv[31] = 1'b1; wr[31] = 1'b1;
    tick(); idle(); tick();
    check_eq("t2_rr_first", 256'(o_lane), 256'(0));
    tick();
    check_eq("t2_rr_second", 256'(o_lane), 256'(31));
    check_eq("t2_rr_valid", 256'(o_valid), 256'(1));

    // Backpressure: six writes on lane 2 into a 4-deep FIFO
    do_clear();
    ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wv[2] = 1'b1; wr[2] = 1'b1; wd[2*DW +: DW] = 32'h100 + k;
      tick();
    end
    idle();
    check_eq("t3_drop2", 256'(o_drop[2*DRW +: DRW]), 256'(1));
    check_eq("t3_ovf2", 256'(o_ovf[2]), 256'(1));
    check_eq("t3_held_data", 256'(o_data), 256'(32'h100));
    ready = 1'b1;
    repeat (8) tick();

    // All three event kinds on lane 7 in one cycle
    do_clear();
    wv[7] = 1'b1; wr[7] = 1'b1; rv[7] = 1'b1; rr[7] = 1'b1; rdv[7] = 1'b1;
    tick(); idle(); tick();
    check_eq("t4_type", 256'(o_type), 256'(0));
    check_eq("t4_drop7", 256'(o_drop[7*DRW +: DRW]), 256'(2));
    check_eq("t4_wo_valid", 256'(b_valid), 256'(1));
    check_eq("t4_wo_type", 256'(b_type), 256'(0));
    check_eq("t4_wo_lane", 256'(b_lane), 256'(7));
    check_eq("t4_wo_drop", 256'(b_drop), 256'(0));
    tick();
    check_eq("t4_only_one", 256'(o_valid), 256'(0));

    // Drop counter saturation, then clear
    do_clear();
    ready = 1'b0;
    wv[1] = 1'b1; wr[1] = 1'b1;
    repeat (310) tick();
    check_eq("t5_sat", 256'(o_drop[1*DRW +: DRW]), 256'(255));
    do_clear();
    check_eq("t5_clr_drop", 256'(o_drop), 256'(0));
    check_eq("t5_clr_ovf", 256'(o_ovf), 256'(0));
    check_eq("t5_clr_valid", 256'(o_valid), 256'(0));
    ready = 1'b1;
    tick(); idle(); tick();
    check_eq("t5_ts_zero", 256'(o_ts), 256'(0));
    check_eq("t5_lane", 256'(o_lane), 256'(1));

    // Reset while a record is held
    do_clear();
    ready = 1'b0;
    wv[4] = 1'b1; wr[4] = 1'b1;
    tick(); idle(); tick();
    check_eq("t6_pre_valid", 256'(o_valid), 256'(1));
    reset_poweron = 1'b1;
    tick();
    check_eq("t6_rst_valid", 256'(o_valid), 256'(0));
    reset_poweron = 1'b0;
    repeat (5) tick();
    check_eq("t6_quiet", 256'(o_valid), 256'(0));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      wv  = NL'($urandom & $urandom & $urandom);
      wr  = NL'($urandom | $urandom);
      rv  = NL'($urandom & $urandom & $urandom);
      rr  = NL'($urandom);
      rdv = NL'($urandom & $urandom & $urandom);
      for (int i = 0; i < NL; i++) begin
        wa[i*AW +: AW] = AW'($urandom);
        ra[i*AW +: AW] = AW'($urandom);
        wd[i*DW +: DW] = DW'($urandom);
        rd[i*DW +: DW] = DW'($urandom);
      end
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 15) != 0);
      clr   = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();
    clr = 1'b0; en = 1'b1; ready = 1'b1;
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dma2mem_txn_monitor.md
# dma2mem_txn_monitor

Synthesizable, parametrised monitor for DMA-to-memory-controller traffic. It sits beside the streaming-op datapath and taps every lane's DMA/memory-controller handshakes, not just stream 0. Each accepted write, read request and read-data return becomes a timestamped record in a per-lane FIFO. A round-robin arbiter drains the FIFOs into one valid/ready record stream for the bench checker or a trace buffer.

## Interface
Parameters:
- NUM_LANES, 32, number of tapped lanes; lane id width LW = $clog2(NUM_LANES), minimum 1
- ADDR_WIDTH, 24, DMA address width
- DATA_WIDTH, 32, DMA data width
- FIFO_DEPTH, 4, per-lane FIFO entries; power of two, ≥2
- TS_WIDTH, 16, timestamp counter width
- CAPTURE_READS, 1, 0 = capture writes only; 1 = capture writes, read requests and read data
- DROP_WIDTH, 8, per-lane drop counter width

Ports:
- clk  in  1  system clock
- reset_poweron  in  1  synchronous, active-high reset
- sys__mon__enable  in  1  capture enable; draining continues when low
- sys__mon__clear  in  1  synchronous clear of FIFOs, drop counters, overflow flags and timestamp
- dma__memc__write_valid  in  NUM_LANES  per-lane write valid
- memc__dma__write_ready  in  NUM_LANES  per-lane write ready
- dma__memc__write_address  in  NUM_LANES*ADDR_WIDTH  lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- dma__memc__write_data  in  NUM_LANES*DATA_WIDTH  flattened as above
- dma__memc__read_valid  in  NUM_LANES  read request valid
- memc__dma__read_ready  in  NUM_LANES  read request ready
- dma__memc__read_address  in  NUM_LANES*ADDR_WIDTH  read address
- memc__dma__read_data_valid  in  NUM_LANES  read data return valid
- memc__dma__read_data  in  NUM_LANES*DATA_WIDTH  read data
- mon__out_valid  out  1  record valid
- out__mon_ready  in  1  consumer ready
- mon__out_lane  out  LW  source lane
- mon__out_type  out  2  record type: 0 WR, 1 RD_REQ, 2 RD_DATA
- mon__out_address  out  ADDR_WIDTH  address; 0 for RD_DATA
- mon__out_data  out  DATA_WIDTH  data; 0 for RD_REQ
- mon__out_timestamp  out  TS_WIDTH  timestamp of the capture cycle
- mon__overflow  out  NUM_LANES  sticky per-lane drop flag
- mon__drop_count  out  NUM_LANES*DROP_WIDTH  per-lane saturating drop counter

## Operation
- Events per lane per cycle, when enabled: WR = write_valid & write_ready. With CAPTURE_READS=1, also RD_REQ = read_valid & read_ready and RD_DATA = read_data_valid.
- Each lane FIFO pushes at most one record per cycle. Priority is WR > RD_DATA > RD_REQ. Each losing event adds 1 to that lane's drop counter and sets mon__overflow[lane].
- FIFO full at the edge: the record is dropped and counted. Exception: if the arbiter pops the same lane at the same edge, the push succeeds.
- Drop counter saturates at 2^DROP_WIDTH-1. Overflow flag stays set until reset or clear.
- Timestamp counter: free-running, increments every cycle, wraps to 0. The record holds the value present in the event cycle.
- Output slot is a single register stage.
  - Loads when empty or when the current record is accepted (valid & ready).
  - Round-robin grant among non-empty FIFOs, starting at the lane after the last granted lane. The pointer resets to lane 0.
- Output fields are held stable while mon__out_valid=1 and out__mon_ready=0.
- sys__mon__clear takes priority over capture and drain in that cycle. It empties FIFOs and the output slot, zeroes counters, flags and timestamp, and resets the grant pointer to 0.

## Timing
- Reset: all outputs 0. FIFOs empty, timestamp 0, grant pointer 0.
- Latency: event in cycle N → written at edge ending N → record in output slot after the next edge. mon__out_valid is high in cycle N+2 if the slot is free.
- Throughput: one record per cycle with out__mon_ready held high.
- Reset or clear asserted mid-transfer: the pending record is discarded. No partial records are ever emitted.
- Deasserting enable stops new pushes from the next event cycle. Already-queued records still drain.
- Timestamp wraps from 2^TS_WIDTH-1 to 0 with no other side effect.

## Test plan
- Single write, lane 3, addr 0x000100, data 0xDEADBEEF, cycle 10 (timestamp 10), ready high → one WR record in cycle 12: lane=3, data DEADBEEF, timestamp=10.
- Lanes 0, 5 and 31 write in the same cycle, out__mon_ready high → records emitted in order 0, 5, 31 on consecutive cycles. A next burst on lanes 0 and 31 emits 0 then 31 under round robin.
- out__mon_ready low, 6 writes on lane 2 (FIFO_DEPTH 4) → one record in the output slot, 4 in the FIFO, 1 dropped. drop_count[2]=1, overflow[2]=1. Releasing ready yields 5 records in order.
- WR, RD_REQ and RD_DATA on lane 7 in one cycle with CAPTURE_READS=1 → only the WR record is emitted; drop_count[7]=2. With CAPTURE_READS=0 → WR record emitted, no drops.
- 300 forced drops on one lane with DROP_WIDTH 8 → counter saturates at 255. sys__mon__clear then zeroes the counter, flag, FIFOs and timestamp.
- Reset asserted while mon__out_valid=1 and ready low → mon__out_valid=0 next cycle, and nothing is emitted after release until new events arrive.
